mcu_datapath: RTL and testbench

- Execution datapath driven by the mcu control unit; it is the consumer side of the mcu control interface.
- Takes the control strobes (ram_write, imm_update, pc_count, pc_load, psr_update, opcode_update, alu_operation, acc_update) plus instruction-memory data.
- Holds PC, immediate/address register, accumulator, data RAM and APSR.
- Returns the apsr flags and the instruction-memory address to the rest of the MCU.

---
 rtl/mcu_datapath_pkg.sv | 35 +++
 rtl/mcu_dp_ram.sv | 24 ++
 rtl/mcu_datapath.sv | 173 +++++++++++++++++
 tb/tb_mcu_datapath.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_datapath_pkg.sv
// Shared constants for the mcu datapath: widths, ALU operation codes,
// APSR bit positions and the RAM-clear state encoding.
package mcu_datapath_pkg;

  localparam int MCU_DATA_WIDTH = 8;
  localparam int MCU_ADDR_WIDTH = 8;
  localparam int MCU_FLAG_WIDTH = 4;
  localparam int MCU_OP_WIDTH   = 3;

  // ALU operation selector codes
  typedef enum logic [MCU_OP_WIDTH-1:0] {
    ALU_PASSB = 3'b000,
    ALU_ADD   = 3'b001,
    ALU_SUB   = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_XOR   = 3'b101,
    ALU_LDI   = 3'b110,
    ALU_NOP   = 3'b111
  } alu_op_e;

  // APSR bit indices, {N,Z,C,V} from bit3 down to bit0
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Post-reset RAM clear sequencer states
  typedef enum logic [1:0] {
    CLR_IDLE  = 2'b00,
    CLR_CLEAR = 2'b01,
    CLR_READY = 2'b10
  } clr_state_e;

endpackage

// File: rtl/mcu_dp_ram.sv
// Data RAM for the mcu datapath: 2**ADDR_WIDTH x DATA_WIDTH,
// synchronous write, asynchronous read on a single address port.
module mcu_dp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Write port
  // NOTE: the array has no reset branch so it maps onto plain RAM; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mcu_datapath.sv
// mcu_datapath: execution datapath driven by the mcu control unit.
// Holds PC, immediate/address register, opcode, accumulator, data RAM and APSR.
// Optional feature macro: MCU_DATAPATH_RAM_CLEAR_EN -- after reset, zero the
// whole RAM (one word per cycle) while dp_ready is low and strobes are ignored.
module mcu_datapath
  import mcu_datapath_pkg::*;
#(
  parameter int DATA_WIDTH = MCU_DATA_WIDTH,
  parameter int ADDR_WIDTH = MCU_ADDR_WIDTH,
  parameter int FLAG_WIDTH = MCU_FLAG_WIDTH,
  parameter int OP_WIDTH   = MCU_OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  ram_write,
  input  logic                  imm_update,
  input  logic                  pc_count,
  input  logic                  pc_load,
  input  logic                  psr_update,
  input  logic                  opcode_update,
  input  logic [OP_WIDTH-1:0]   alu_operation,
  input  logic                  acc_update,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] acc,
  output logic [FLAG_WIDTH-1:0] apsr,
  output logic                  dp_ready
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [DATA_WIDTH-1:0] r_opcode;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [FLAG_WIDTH-1:0] r_apsr;

  logic                  w_ready;
  logic                  w_clearing;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic [ADDR_WIDTH-1:0] w_imm_addr;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  logic [DATA_WIDTH-1:0] w_result;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_diff;
  logic [FLAG_WIDTH-1:0] w_flags;

  assign w_imm_addr = r_imm[ADDR_WIDTH-1:0];

`ifdef MCU_DATAPATH_RAM_CLEAR_EN
  clr_state_e            r_clr_state;
  clr_state_e            w_clr_state_next;
  logic [ADDR_WIDTH-1:0] r_clr_addr;

  // Clear sequencer state register; reset holds it in IDLE
  always_ff @(posedge clk) begin
    if (rst) r_clr_state <= CLR_IDLE;
    else     r_clr_state <= w_clr_state_next;
  end

  // Clear address walks 0..2**ADDR_WIDTH-1 while in CLEAR; reset restarts it
  always_ff @(posedge clk) begin
    if (rst)                          r_clr_addr <= '0;
    else if (r_clr_state == CLR_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
  end

  // Next-state logic: leave CLEAR after the last address has been written
  always_comb begin
    w_clr_state_next = r_clr_state;
    case (r_clr_state)
      CLR_IDLE:  w_clr_state_next = CLR_CLEAR;
      CLR_CLEAR: if (r_clr_addr == '1) w_clr_state_next = CLR_READY;
      CLR_READY: w_clr_state_next = CLR_READY;
      default:   w_clr_state_next = CLR_IDLE;
    endcase
  end

  // Sequencer outputs
  always_comb begin
    w_ready    = (r_clr_state == CLR_READY);
    w_clearing = (r_clr_state == CLR_CLEAR);
    w_clr_addr = r_clr_addr;
  end
`else
  logic r_ready;

  // Ready goes high on the first edge after reset is released
  always_ff @(posedge clk) begin
    if (rst) r_ready <= 1'b0;
    else     r_ready <= 1'b1;
  end

  assign w_ready    = r_ready;
  assign w_clearing = 1'b0;
  assign w_clr_addr = '0;
`endif

  // RAM port: the clear sequencer owns it while clearing, otherwise imm_q addresses it
  assign w_ram_we    = w_clearing | (ram_write & w_ready);
  assign w_ram_addr  = w_clearing ? w_clr_addr : w_imm_addr;
  assign w_ram_wdata = w_clearing ? '0 : r_acc;

  mcu_dp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // ALU and flag generation: A=acc, B=RAM[imm_q]; C/V hold unless ADD/SUB
  // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
  always_comb begin
    w_result        = r_acc;
    w_sum           = {1'b0, r_acc} + {1'b0, w_ram_rdata};
    w_diff          = {1'b0, r_acc} - {1'b0, w_ram_rdata};
    w_flags         = r_apsr;
    case (alu_op_e'(alu_operation))
      ALU_PASSB: w_result = w_ram_rdata;
      ALU_ADD: begin
        w_result        = w_sum[MSB:0];
        w_flags[FLAG_C] = w_sum[DATA_WIDTH];
        w_flags[FLAG_V] = (r_acc[MSB] == w_ram_rdata[MSB]) && (w_sum[MSB] != r_acc[MSB]);
      end
      ALU_SUB: begin
        w_result        = w_diff[MSB:0];
        w_flags[FLAG_C] = ~w_diff[DATA_WIDTH];
        w_flags[FLAG_V] = (r_acc[MSB] != w_ram_rdata[MSB]) && (w_diff[MSB] != r_acc[MSB]);
      end
      ALU_AND: w_result = r_acc & w_ram_rdata;
      ALU_OR:  w_result = r_acc | w_ram_rdata;
      ALU_XOR: w_result = r_acc ^ w_ram_rdata;
      ALU_LDI: w_result = r_imm;
      default: w_result = r_acc;
    endcase
    w_flags[FLAG_N] = w_result[MSB];
    w_flags[FLAG_Z] = (w_result == '0);
  end

  // Architectural registers; strobes take effect only while ready
  // NOTE: non-blocking assignments make every register read its pre-edge value, which gives the same-cycle hazard behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= '0;
      r_imm    <= '0;
      r_opcode <= '0;
      r_acc    <= '0;
      r_apsr   <= '0;
    end else if (w_ready) begin
      if (pc_load)       r_pc     <= w_imm_addr;
      else if (pc_count) r_pc     <= r_pc + 1'b1;
      if (imm_update)    r_imm    <= imem_data;
      if (opcode_update) r_opcode <= imem_data;
      if (acc_update)    r_acc    <= w_result;
      if (psr_update)    r_apsr   <= w_flags;
    end
  end

  assign imem_addr = r_pc;
  assign opcode    = r_opcode;
  assign acc       = r_acc;
  assign apsr      = r_apsr;
  assign dp_ready  = w_ready;

endmodule

// File: tb/tb_mcu_datapath.sv
// Self-checking bench for mcu_datapath: directed scenarios plus randomized
// strobes, compared against an integer-arithmetic reference model.
// Honours MCU_DATAPATH_RAM_CLEAR_EN when the design is built with it.
module tb_mcu_datapath;
  import mcu_datapath_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] imem_data;
  logic       ram_write, imm_update, pc_count, pc_load;
  logic       psr_update, opcode_update, acc_update;
  logic [2:0] alu_operation;
  logic [7:0] imem_addr, opcode, acc;
  logic [3:0] apsr;
  logic       dp_ready;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_pc, m_imm, m_op, m_acc, m_n, m_z, m_c, m_v, m_ready;
  int m_ram [256];

  mcu_datapath dut (
    .clk           (clk),
    .rst           (rst),
    .imem_data     (imem_data),
    .ram_write     (ram_write),
    .imm_update    (imm_update),
    .pc_count      (pc_count),
    .pc_load       (pc_load),
    .psr_update    (psr_update),
    .opcode_update (opcode_update),
    .alu_operation (alu_operation),
    .acc_update    (acc_update),
    .imem_addr     (imem_addr),
    .opcode        (opcode),
    .acc           (acc),
    .apsr          (apsr),
    .dp_ready      (dp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed8(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  function automatic int out_of_range(input int s);
    return (s < -128 || s > 127) ? 1 : 0;
  endfunction

  task automatic compare_all();
    check("pc",       {24'd0, imem_addr}, m_pc);
    check("opcode",   {24'd0, opcode},    m_op);
    check("acc",      {24'd0, acc},       m_acc);
    check("apsr",     {28'd0, apsr},      (m_n << 3) | (m_z << 2) | (m_c << 1) | m_v);
    check("dp_ready", {31'd0, dp_ready},  m_ready);
  endtask

  task automatic idle_inputs();
    imem_data = 8'h00; ram_write = 0; imm_update = 0; pc_count = 0; pc_load = 0;
    psr_update = 0; opcode_update = 0; acc_update = 0; alu_operation = 3'b111;
  endtask

  // One clock with the given strobes; model advances from pre-edge state.
  task automatic step(input int data, input bit rw, input bit iu, input bit pcc,
                      input bit pcl, input bit psu, input bit ou, input int op, input bit au);
    int a, b, res, c, v;
    imem_data = data[7:0]; ram_write = rw; imm_update = iu; pc_count = pcc;
    pc_load = pcl; psr_update = psu; opcode_update = ou; acc_update = au;
    alu_operation = op[2:0];
    a = m_acc; b = m_ram[m_imm]; res = a; c = m_c; v = m_v;
    case (op)
      0: res = b;
      1: begin res = (a + b) % 256; c = (a + b > 255);
               v = out_of_range(to_signed8(a) + to_signed8(b)); end
      2: begin res = (a - b + 256) % 256; c = (a >= b);
               v = out_of_range(to_signed8(a) - to_signed8(b)); end
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: res = m_imm;
      default: res = a;
    endcase
    if (m_ready != 0) begin
      if (rw) m_ram[m_imm] = a;
      if (pcl) m_pc = m_imm;
      else if (pcc) m_pc = (m_pc + 1) % 256;
      if (iu) m_imm = data & 255;
      if (ou) m_op = data & 255;
      if (au) m_acc = res;
      if (psu) begin m_n = (res >= 128); m_z = (res == 0); m_c = c; m_v = v; end
    end
    m_ready = 1;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // Reset with all strobes active; they must be ignored.
  task automatic do_reset(input int cycles);
    rst = 1;
    imem_data = 8'($urandom); ram_write = 1; imm_update = 1; pc_count = 1; pc_load = 1;
    psr_update = 1; opcode_update = 1; acc_update = 1; alu_operation = 3'b001;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("ready_in_reset", {31'd0, dp_ready}, 0);
    end
    m_pc = 0; m_imm = 0; m_op = 0; m_acc = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_ready = 0;
    compare_all();
    idle_inputs();
    rst = 0;
  endtask

`ifdef MCU_DATAPATH_RAM_CLEAR_EN
  // Count low-ready cycles after release while firing strobes at the DUT.
  task automatic wait_clear();
    int low_cycles = 0;
    bit done = 0;
    ram_write = 1; imm_update = 1; pc_count = 1; acc_update = 1; psr_update = 1;
    opcode_update = 1; alu_operation = 3'b110; imem_data = 8'h5A;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (dp_ready) done = 1;
      else low_cycles++;
    end
    check("clear_done", {31'd0, done}, 1);
    check("clear_low_cycles", low_cycles, 256);
    idle_inputs();
    for (int i = 0; i < 256; i++) m_ram[i] = 0;
    m_ready = 1;
    compare_all();
    for (int i = 0; i < 256; i++) begin
      step(i, 0, 1, 0, 0, 0, 0, ALU_NOP, 0);
      step(0, 0, 0, 0, 0, 0, 0, ALU_PASSB, 1);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1;
    for (int i = 0; i < 256; i++) m_ram[i] = 0;
    do_reset(3);
`ifdef MCU_DATAPATH_RAM_CLEAR_EN
    wait_clear();
`else
    step(0, 0, 0, 0, 0, 0, 0, ALU_NOP, 0);
`endif
    check("ready_after_release", {31'd0, dp_ready}, 1);

    // PC wrap and load priority
    repeat (256) step(0, 0, 0, 1, 0, 0, 0, ALU_NOP, 0);
    check("pc_wrap", {24'd0, imem_addr}, 32'h00);
    step(8'h40, 0, 1, 0, 0, 0, 0, ALU_NOP, 0);
    step(0, 0, 0, 1, 1, 0, 0, ALU_NOP, 0);
    check("pc_load_prio", {24'd0, imem_addr}, 32'h40);

    // opcode capture
    step(8'hC3, 0, 0, 0, 0, 0, 1, ALU_NOP, 0);
    check("opcode_capture", {24'd0, opcode}, 32'hC3);

    // load / store / add
    step(8'h05, 0, 1, 0, 0, 0, 0, ALU_NOP, 0);
    step(0, 0, 0, 0, 0, 0, 0, ALU_LDI, 1);
    check("ldi_acc", {24'd0, acc}, 32'h05);
    step(8'hAE, 0, 1, 0, 0, 0, 0, ALU_NOP, 0);
    step(0, 1, 0, 0, 0, 0, 0, ALU_NOP, 0);
    step(0, 0, 0, 0, 0, 1, 0, ALU_ADD, 1);
    check("add_acc", {24'd0, acc}, 32'h0A);
    check("add_apsr", {28'd0, apsr}, 32'h0);

    // subtract to zero
    step(0, 0, 0, 0, 0, 0, 0, ALU_PASSB, 1);
    check("passb_acc", {24'd0, acc}, 32'h05);
    step(0, 0, 0, 0, 0, 1, 0, ALU_SUB, 1);
    check("sub_acc", {24'd0, acc}, 32'h00);
    check("sub_apsr", {28'd0, apsr}, 32'h6);

    // signed overflow
    step(8'h01, 0, 1, 0, 0, 0, 0, ALU_NOP, 0);
    step(0, 0, 0, 0, 0, 0, 0, ALU_LDI, 1);
    step(8'h30, 0, 1, 0, 0, 0, 0, ALU_NOP, 0);
    step(0, 1, 0, 0, 0, 0, 0, ALU_NOP, 0);
    step(8'h7F, 0, 1, 0, 0, 0, 0, ALU_NOP, 0);
    step(0, 0, 0, 0, 0, 0, 0, ALU_LDI, 1);
    step(8'h30, 0, 1, 0, 0, 0, 0, ALU_NOP, 0);
    step(0, 0, 0, 0, 0, 1, 0, ALU_ADD, 1);
    check("ovf_acc", {24'd0, acc}, 32'h80);
    check("ovf_apsr", {28'd0, apsr}, 32'h9);

    // same-cycle hazard: RAM gets old acc while acc loads immediate
    step(8'h11, 0, 1, 0, 0, 0, 0, ALU_NOP, 0);
    step(0, 0, 0, 0, 0, 0, 0, ALU_LDI, 1);
    step(8'h22, 0, 1, 0, 0, 0, 0, ALU_NOP, 0);
    step(0, 1, 0, 0, 0, 0, 0, ALU_LDI, 1);
    check("hazard_acc", {24'd0, acc}, 32'h22);
    step(0, 0, 0, 0, 0, 0, 0, ALU_PASSB, 1);
    check("hazard_ram", {24'd0, acc}, 32'h11);

    // same-cycle: pc_load and imm_update use old imm_q
    step(8'h99, 0, 1, 0, 1, 0, 0, ALU_NOP, 0);
    check("pcload_old_imm", {24'd0, imem_addr}, 32'h22);

    // fill every RAM word with its own address so random reads are defined
    for (int a = 0; a < 256; a++) begin
      step(a, 0, 1, 0, 0, 0, 0, ALU_NOP, 0);
      step(0, 0, 0, 0, 0, 0, 0, ALU_LDI, 1);
      step(0, 1, 0, 0, 0, 0, 0, ALU_NOP, 0);
    end

    // randomized strobes
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
    end

    // reset mid-run returns registers to zero
    do_reset(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
